// File: rtl/ex_trap_ctrl.sv
// External-trap request controller: synchronise, latch, prioritise, handshake.
// Optional request timeout is enabled with `define EX_TRAP_TIMEOUT_EN.
module ex_trap_ctrl #(
  parameter int SRC_NUM     = 8,
  parameter int ID_W        = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SRC_NUM-1:0] irq_src,
  input  logic [SRC_NUM-1:0] irq_edge,
  input  logic [SRC_NUM-1:0] irq_en,
  output logic               core_ex_trap_valid,
  input  logic               core_ex_trap_ready,
  output logic [ID_W-1:0]    trap_id,
  output logic [SRC_NUM-1:0] pending,
  output logic               timeout_err
);

  if (SRC_NUM < 1 || SRC_NUM > 32 ||
      (2 ** ID_W) < SRC_NUM ||
      SYNC_STAGES < 2 || TIMEOUT < 2) begin : g_param_err
    $error("ex_trap_ctrl: illegal parameters");
  end

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0][SRC_NUM-1:0] sync_q;
  logic [SRC_NUM-1:0] s;
  logic [SRC_NUM-1:0] d;
  logic [SRC_NUM-1:0] rise;
  logic [SRC_NUM-1:0] set_v;
  logic [SRC_NUM-1:0] fly;
  logic [SRC_NUM-1:0] done;
  logic [SRC_NUM-1:0] clr_v;
  logic [SRC_NUM-1:0] pend_nx;
  logic [ID_W-1:0]    first_id;

  function automatic logic [ID_W-1:0] lowest(
    input logic [SRC_NUM-1:0] v
  );
    lowest = '0;
    for (int i = SRC_NUM - 1; i >= 0; i--)
      if (v[i]) lowest = ID_W'(i);
  endfunction

  assign s     = sync_q[SYNC_STAGES-1];
  assign rise  = s & ~d;
  assign set_v = irq_en &
                 ((irq_edge & rise) | (~irq_edge & s));

  // The in-flight source is shielded from the disable-clear.
  assign fly   = (state == REQ) ?
                 (SRC_NUM'(1) << trap_id) : '0;
  assign done  = core_ex_trap_ready ? fly : '0;
  assign clr_v = done | (~irq_en & ~fly);

  // Set wins over clear so a coincident edge is kept.
  assign pend_nx  = set_v | (pending & ~clr_v);
  assign first_id = lowest(pending);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      d      <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src};
      d      <= s;
    end
  end

`ifdef EX_TRAP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] to_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      core_ex_trap_valid <= 1'b0;
      trap_id            <= '0;
      pending            <= '0;
`ifdef EX_TRAP_TIMEOUT_EN
      to_cnt             <= '0;
      timeout_err        <= 1'b0;
`endif
    end else begin
      pending <= pend_nx;
`ifdef EX_TRAP_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (|pending) begin
            trap_id            <= first_id;
            core_ex_trap_valid <= 1'b1;
            state              <= REQ;
`ifdef EX_TRAP_TIMEOUT_EN
            to_cnt             <= '0;
`endif
          end
        end
        REQ: begin
          if (core_ex_trap_ready) begin
            core_ex_trap_valid <= 1'b0;
            state              <= IDLE;
          end
`ifdef EX_TRAP_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
            core_ex_trap_valid <= 1'b0;
            state              <= IDLE;
            timeout_err        <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
